// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DIV_WIDTH    default operand/result width
//   div_state_t  FSM encoding (3-bit)
//   cnt_width()  width of the iteration counter for a given operand width
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } div_state_t;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_abs_neg.sv
// Combinational two's-complement negate with enable.
//   a   in   WIDTH  operand
//   en  in   1      1: y = -a, 0: y = a
//   y   out  WIDTH  result
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic [WIDTH-1:0] y
);

    assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle signed divider (restoring, one quotient bit per cycle).
// Quotient truncates toward zero, remainder carries the dividend's sign.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   clr        in   1      asynchronous active-low reset
//   start      in   1      request, sampled only in IDLE
//   dividend   in   WIDTH  signed dividend, captured on acceptance
//   divisor    in   WIDTH  signed divisor, captured on acceptance
//   busy       out  1      operation in progress (PREP/ITER/FIXUP)
//   done       out  1      one-cycle pulse, results valid from this cycle
//   quotient   out  WIDTH  signed quotient, held until the next result
//   remainder  out  WIDTH  signed remainder, held until the next result
//   div_zero   out  1      zero divisor seen, valid with done
//
// Build option DIV_ZERO_TRAP_EN: a zero divisor skips the iterations and
// raises div_zero with done. Without it div_zero is tied low and a zero
// divisor runs the full sequence.
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | waiting for start; operands captured on acceptance
//   ST_PREP   | load magnitudes, latch result signs
//   ST_ITER   | WIDTH shift/subtract steps
//   ST_FIXUP  | sign-correct and register quotient/remainder
//   ST_DONE   | done pulse, back to IDLE
module seq_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             dvs_neg;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;

    logic [WIDTH-1:0] abs_in;
    logic [WIDTH-1:0] abs_out;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic [WIDTH:0]   shifted_r;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;
    logic             last_iter;
    logic             dvs_zero;

    // One negator serves both operands: the divisor magnitude is taken
    // while IDLE (at acceptance), the dividend magnitude in PREP.
    assign abs_in = (state == ST_IDLE) ? divisor : dvd_q;

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_op (
        .a  (abs_in),
        .en (abs_in[WIDTH-1]),
        .y  (abs_out)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
        .a  (q_q),
        .en (sign_q),
        .y  (q_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
        .a  (r_q),
        .en (sign_r),
        .y  (r_fix)
    );

    // WIDTH+1-bit trial: compare decides the quotient bit, and the low
    // WIDTH bits of the difference are the new partial remainder. With a
    // zero divisor the compare always passes, so Q fills with ones and R
    // ends up holding the dividend magnitude.
    assign shifted_r  = {r_q, q_q[WIDTH-1]};
    assign trial_ge   = (shifted_r >= {1'b0, dvs_q});
    assign trial_diff = shifted_r[WIDTH-1:0] - dvs_q;
    assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_TRAP_EN
    logic zero_q;
    assign dvs_zero = (dvs_q == '0);
`else
    assign dvs_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_PREP;
            ST_PREP:  state_nxt = dvs_zero ? ST_FIXUP : ST_ITER;
            ST_ITER:  if (last_iter) state_nxt = ST_FIXUP;
            ST_FIXUP: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIXUP);
        done = (state == ST_DONE);
`ifdef DIV_ZERO_TRAP_EN
        div_zero = zero_q && (state == ST_DONE);
`else
        div_zero = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt       <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dvs_neg   <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            r_q       <= '0;
            q_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_TRAP_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd_q   <= dividend;
                        dvs_q   <= abs_out;
                        dvs_neg <= divisor[WIDTH-1];
                    end
                end
                ST_PREP: begin
                    cnt    <= '0;
                    sign_r <= dvd_q[WIDTH-1];
`ifdef DIV_ZERO_TRAP_EN
                    zero_q <= dvs_zero;
`endif
                    if (dvs_zero) begin
                        // Skip straight to FIXUP with the trap results staged.
                        sign_q <= 1'b0;
                        q_q    <= '1;
                        r_q    <= abs_out;
                    end else begin
                        sign_q <= dvd_q[WIDTH-1] ^ dvs_neg;
                        q_q    <= abs_out;
                        r_q    <= '0;
                    end
                end
                ST_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    r_q <= trial_ge ? trial_diff : shifted_r[WIDTH-1:0];
                    q_q <= {q_q[WIDTH-2:0], trial_ge};
                end
                ST_FIXUP: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_unit.sv
module tb_seq_div_unit;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    seq_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_chk    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    localparam int LAT_FULL = 35;
`ifdef DIV_ZERO_TRAP_EN
    localparam int LAT_ZERO = 3;
`else
    localparam int LAT_ZERO = 35;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!clr) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("quotient",  quotient,  mon_e.q);
                    chk("remainder", remainder, mon_e.r);
                    chk("div_zero",  32'(div_zero), 32'(mon_e.dz));
                    chk("latency",   32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                    chk("busy_cycles", 32'(busy_cnt), 32'(mon_e.lat - 1));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("pending_results", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int lat);
        exp_t e;
        @(negedge clk);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0BAD_F00D;
        e.q = q; e.r = r; e.dz = dz; e.lat = lat; e.acc = cyc;
        exp_q.push_back(e);
        wait_drain();
    endtask

    initial begin
        exp_t e;
        int   acc1;

        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1 clr = 1'b0;
        #1;
        chk("rst_busy",      32'(busy),     32'd0);
        chk("rst_done",      32'(done),     32'd0);
        chk("rst_div_zero",  32'(div_zero), 32'd0);
        chk("rst_quotient",  quotient,      32'd0);
        chk("rst_remainder", remainder,     32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        run_op(32'd100,        32'd7,        32'd14,       32'd2,        1'b0, LAT_FULL);
        run_op(-32'sd100,      32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT_FULL);
        run_op(32'd100,        -32'sd7,      32'hFFFFFFF2, 32'd2,        1'b0, LAT_FULL);
        run_op(-32'sd100,      -32'sd7,      32'd14,       32'hFFFFFFFE, 1'b0, LAT_FULL);
        run_op(32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, LAT_FULL);
        run_op(32'd7,          32'd100,      32'd0,        32'd7,        1'b0, LAT_FULL);
        run_op(32'd0,          32'd5,        32'd0,        32'd0,        1'b0, LAT_FULL);
        run_op(32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, LAT_FULL);
        run_op(32'hFFFFFFFF,   32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, LAT_FULL);
        run_op(32'h80000000,   32'h80000000, 32'd1,        32'd0,        1'b0, LAT_FULL);
        run_op(-32'sd7,        32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT_FULL);
`ifdef DIV_ZERO_TRAP_EN
        run_op(32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, LAT_ZERO);
        run_op(-32'sd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, LAT_ZERO);
`else
        run_op(32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, LAT_ZERO);
        run_op(-32'sd5,        32'd0,        32'd1,        32'hFFFFFFFB, 1'b0, LAT_ZERO);
`endif
        run_op(32'd100,        32'd7,        32'd14,       32'd2,        1'b0, LAT_FULL);

        // Reset in the middle of an operation: no result may appear.
        @(negedge clk);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (9) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("midrst_busy",      32'(busy),     32'd0);
        chk("midrst_done",      32'(done),     32'd0);
        chk("midrst_div_zero",  32'(div_zero), 32'd0);
        chk("midrst_quotient",  quotient,      32'd0);
        chk("midrst_remainder", remainder,     32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (40) @(negedge clk);
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT_FULL);

        // start held high: second op accepted 36 cycles after the first,
        // pulses while busy are ignored and operand noise has no effect.
        @(negedge clk);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        acc1 = cyc;
        e.q = 32'd14; e.r = 32'd2; e.dz = 1'b0; e.lat = LAT_FULL; e.acc = acc1;
        exp_q.push_back(e);
        e.q = 32'hFFFFFFF2; e.r = 32'hFFFFFFFE; e.dz = 1'b0; e.lat = LAT_FULL; e.acc = acc1 + 36;
        exp_q.push_back(e);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k >= 5 && k <= 20) begin
                start    = (k % 2) == 1;
                dividend = $urandom;
                divisor  = $urandom;
            end else if (k == 21) begin
                start    = 1'b1;
                dividend = -32'sd100;
                divisor  = 32'd7;
            end else if (k == 36) begin
                start    = 1'b0;
            end
        end
        wait_drain();

        repeat (5) @(negedge clk);
        chk("idle_after_all", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
